// File: rtl/mcu_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes, FSM states
// and fault codes.
package mcu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_XCHG  = 4'd2;
    localparam logic [3:0] OP_IN    = 4'd3;
    localparam logic [3:0] OP_OUT   = 4'd4;
    localparam logic [3:0] OP_INC   = 4'd5;
    localparam logic [3:0] OP_MOV_M = 4'd6;
    localparam logic [3:0] OP_MOV_I = 4'd7;
    localparam logic [3:0] OP_JZ    = 4'd8;
    localparam logic [3:0] OP_PUSH  = 4'd9;
    localparam logic [3:0] OP_POP   = 4'd10;
    localparam logic [3:0] OP_RCL   = 4'd11;
    localparam logic [3:0] OP_CALL  = 4'd12;
    localparam logic [3:0] OP_RET   = 4'd13;
    localparam logic [3:0] OP_AND   = 4'd14;
    localparam logic [3:0] OP_HLT   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WAIT_IN = 3'd3,
        ST_HALT    = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OVF  = 2'd1;
    localparam logic [1:0] FLT_UDF  = 2'd2;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mcu_stack.sv
// Parametrised LIFO used for PUSH/POP and CALL/RET; the caller must not push
// when full or pop when empty.
module mcu_stack #(
    parameter int DEPTH = 16,
    parameter int W     = 4
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;

    assign wr_idx_s = IDX_W'(sp_q);
    assign rd_idx_s = IDX_W'(sp_q - 1'b1);
    assign rdata_o  = mem_q[rd_idx_s];
    assign full_o   = (sp_q == SP_W'(DEPTH));
    assign empty_o  = ~|sp_q;

    // Stack pointer: clear dominates, push and pop are never issued together
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            sp_q <= {SP_W{1'b0}};
        end else if (push_i) begin
            sp_q <= sp_q + 1'b1;
        end else if (pop_i) begin
            sp_q <= sp_q - 1'b1;
        end else begin
            sp_q <= sp_q;
        end
    end

    // Entry storage, no reset so contents need not be initialised
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[wr_idx_s] <= wdata_i;
        end
    end

endmodule

// File: rtl/mcu_core_param.sv
// Single-clock accumulator core with load/run/halt modes, valid/ready input
// and stack fault detection; 2 cycles per instruction (FETCH, EXEC).
module mcu_core_param
    import mcu_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 16
) (
    input  logic                prog_clk,
    input  logic                reset,
    input  logic                run,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [4+ADDR_W-1:0] prog_data,
    input  logic                data_we,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                halted,
    output logic [1:0]          fault,
    output logic [ADDR_W-1:0]   ip_dbg
);

    localparam int SW    = max_w(DATA_W, ADDR_W);
    localparam int IW    = 4 + ADDR_W;
    localparam int MEM_N = 2 ** ADDR_W;

    state_e            state_q;
    logic [IW-1:0]     pmem_q [MEM_N];
    logic [DATA_W-1:0] dmem_q [MEM_N];
    logic [IW-1:0]     ir_q;
    logic [DATA_W-1:0] a_q, b_q, a_d, b_d, out_data_q;
    logic [ADDR_W-1:0] ip_q, ip_d;
    logic              zf_q, zf_d;
    logic              out_valid_q, in_ready_q, halted_q;
    logic [1:0]        fault_q;

    logic [3:0]        op_s;
    logic [ADDR_W-1:0] opnd_s, ip_plus_s;
    logic [SW-1:0]     opnd_ext_s, stk_wdata_s, stk_rdata_s;
    logic [DATA_W-1:0] mem_rd_s;
    logic              idle_like_s, load_en_s, start_s, exec_s;
    logic              push_op_s, pop_op_s, ovf_s, udf_s;
    logic              stk_push_s, stk_pop_s, stk_clear_s, stk_full_s, stk_empty_s;

    assign op_s        = ir_q[IW-1 -: 4];
    assign opnd_s      = ir_q[ADDR_W-1:0];
    assign opnd_ext_s  = SW'(opnd_s);
    assign ip_plus_s   = ip_q + 1'b1;
    assign mem_rd_s    = dmem_q[opnd_s];

    assign idle_like_s = (state_q == ST_IDLE) || (state_q == ST_HALT) || (state_q == ST_FAULT);
    assign load_en_s   = idle_like_s && !reset;
    assign start_s     = idle_like_s && run;
    assign exec_s      = (state_q == ST_EXEC) && !reset;

    // Faulting stack instructions are caught here so they never touch the LIFO
    assign push_op_s   = (op_s == OP_PUSH) || (op_s == OP_CALL);
    assign pop_op_s    = (op_s == OP_POP) || (op_s == OP_RET);
    assign ovf_s       = push_op_s && stk_full_s;
    assign udf_s       = pop_op_s && stk_empty_s;
    assign stk_push_s  = exec_s && push_op_s && !stk_full_s;
    assign stk_pop_s   = exec_s && pop_op_s && !stk_empty_s;
    assign stk_clear_s = reset || start_s;
    assign stk_wdata_s = (op_s == OP_CALL) ? SW'(ip_plus_s) : SW'(b_q);

    mcu_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (SW)
    ) u_stack (
        .clk_i   (prog_clk),
        .clear_i (stk_clear_s),
        .push_i  (stk_push_s),
        .pop_i   (stk_pop_s),
        .wdata_i (stk_wdata_s),
        .rdata_o (stk_rdata_s),
        .full_o  (stk_full_s),
        .empty_o (stk_empty_s)
    );

    // Program memory load port
    always_ff @(posedge prog_clk) begin
        if (load_en_s && prog_we) begin
            pmem_q[prog_addr] <= prog_data;
        end
    end

    // Data memory load port, shares the load address with program memory
    always_ff @(posedge prog_clk) begin
        if (load_en_s && data_we) begin
            dmem_q[prog_addr] <= data_wdata;
        end
    end

    // Instruction decode: next A, B, ZF and IP for the EXEC cycle
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        zf_d = zf_q;
        ip_d = ip_plus_s;
        case (op_s)
            OP_ADD:   begin a_d = a_q + b_q;             zf_d = ~|a_d; end
            OP_SUB:   begin a_d = a_q - b_q;             zf_d = ~|a_d; end
            OP_XCHG:  begin a_d = b_q; b_d = a_q;        zf_d = ~|b_d; end
            OP_INC:   begin a_d = a_q + 1'b1;            zf_d = ~|a_d; end
            OP_MOV_M: begin a_d = mem_rd_s;              zf_d = ~|a_d; end
            OP_MOV_I: begin a_d = opnd_ext_s[DATA_W-1:0]; zf_d = ~|a_d; end
            OP_AND:   begin a_d = a_q & mem_rd_s;        zf_d = ~|a_d; end
            OP_POP:   begin b_d = stk_rdata_s[DATA_W-1:0]; zf_d = ~|b_d; end
            OP_RCL:   begin b_d = {b_q[DATA_W-2:0], b_q[DATA_W-1]}; zf_d = ~|b_d; end
            OP_JZ: begin
                if (zf_q) begin
                    ip_d = opnd_s;
                end else begin
                    ip_d = ip_plus_s;
                end
            end
            OP_CALL:  ip_d = opnd_s;
            OP_RET:   ip_d = stk_rdata_s[ADDR_W-1:0];
            OP_IN:    ip_d = ip_q;
            OP_HLT:   ip_d = ip_q;
            default:  ip_d = ip_plus_s;
        endcase
    end

    // Control FSM with architectural and output registers
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= {DATA_W{1'b0}};
            b_q         <= {DATA_W{1'b0}};
            ip_q        <= {ADDR_W{1'b0}};
            zf_q        <= 1'b0;
            ir_q        <= {IW{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= FLT_NONE;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_HALT, ST_FAULT: begin
                    if (run) begin
                        a_q      <= {DATA_W{1'b0}};
                        b_q      <= {DATA_W{1'b0}};
                        ip_q     <= {ADDR_W{1'b0}};
                        zf_q     <= 1'b0;
                        fault_q  <= FLT_NONE;
                        halted_q <= 1'b0;
                        state_q  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir_q    <= pmem_q[ip_q];
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (ovf_s) begin
                        fault_q <= FLT_OVF;
                        state_q <= ST_FAULT;
                    end else if (udf_s) begin
                        fault_q <= FLT_UDF;
                        state_q <= ST_FAULT;
                    end else begin
                        a_q  <= a_d;
                        b_q  <= b_d;
                        zf_q <= zf_d;
                        ip_q <= ip_d;
                        case (op_s)
                            OP_IN: begin
                                in_ready_q <= 1'b1;
                                state_q    <= ST_WAIT_IN;
                            end
                            OP_HLT: begin
                                halted_q <= 1'b1;
                                state_q  <= ST_HALT;
                            end
                            OP_OUT: begin
                                out_data_q  <= a_q;
                                out_valid_q <= 1'b1;
                                state_q     <= ST_FETCH;
                            end
                            default: state_q <= ST_FETCH;
                        endcase
                    end
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        a_q        <= in_data;
                        zf_q       <= ~|in_data;
                        ip_q       <= ip_plus_s;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign ip_dbg    = ip_q;

endmodule
